// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//
// Fetch/decode stage sitting directly behind a combinational instruction ROM.
// Owns the program counter, strobes the ROM, captures the 12-bit instruction
// word and presents its opcode/dst/src/imm fields to the execute stage over a
// valid/ready handshake. A redirect (jump) is taken on the accepting
// handshake. A HALT opcode stops fetching until reset.
//
// Optional feature macro: INSTR_CNT_EN
//   When defined, adds a 16-bit saturating count of accepted instructions.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   run          in   1        permits a new fetch (looked at only in FETCH)
//   rom_en       out  1        ROM read strobe, high only in FETCH
//   rom_addr     out  ADDR_W   ROM address (current PC)
//   rom_instr    in   INSTR_W  ROM data, valid in the same cycle as rom_addr
//   jump_en      in   1        redirect PC on the accepting handshake
//   jump_addr    in   ADDR_W   redirect target
//   out_valid    out  1        decoded instruction valid
//   out_ready    in   1        execute stage accepts
//   opcode       out  4        instr[11:8]
//   dst          out  2        instr[7:6]
//   src          out  2        instr[5:4]
//   imm          out  4        instr[3:0]
//   pc_out       out  ADDR_W   address of the presented instruction
//   halted       out  1        high in HALT state
//   instr_count  out  16       accepted-instruction count (INSTR_CNT_EN only)
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
    parameter int         ADDR_W    = 2,
    parameter int         INSTR_W   = 12,
    parameter int         ROM_DEPTH = 4,
    parameter logic [3:0] HALT_OP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        opcode,
    output logic [1:0]        dst,
    output logic [1:0]        src,
    output logic [3:0]        imm,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
`ifdef INSTR_CNT_EN
    ,
    output logic [15:0]       instr_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_HOLD   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic [ADDR_W-1:0]    r_instr_pc;
    logic                 r_out_valid;
    logic [3:0]           r_opcode;
    logic [1:0]           r_dst;
    logic [1:0]           r_src;
    logic [3:0]           r_imm;
    logic [ADDR_W-1:0]    r_pc_out;
    logic                 w_accept;
    logic                 w_jump_ok;
    logic [ADDR_W-1:0]    w_pc_next;

    assign w_accept  = (r_state == S_HOLD) && out_ready;
    // Out-of-range redirect targets fall back to address 0.
    assign w_jump_ok = (32'(jump_addr) < 32'(ROM_DEPTH));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (run) w_next = S_DECODE;
            S_DECODE: w_next = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    w_next = (r_opcode == HALT_OP) ? S_HALT : S_FETCH;
                end
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // PC update on the accepting handshake; HALT keeps the PC and wins over a jump.
    always_comb begin
        w_pc_next = r_pc;
        if (r_opcode != HALT_OP) begin
            if (jump_en) begin
                w_pc_next = w_jump_ok ? jump_addr : '0;
            end else begin
                w_pc_next = (r_pc == LAST_ADDR) ? '0 : r_pc + 1'b1;
            end
        end
    end

    // Datapath: capture in FETCH, present in DECODE, release in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_dst       <= '0;
            r_src       <= '0;
            r_imm       <= '0;
            r_pc_out    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (run) begin
                        r_instr    <= rom_instr;
                        r_instr_pc <= r_pc;
                    end
                end
                S_DECODE: begin
                    r_opcode    <= r_instr[11:8];
                    r_dst       <= r_instr[7:6];
                    r_src       <= r_instr[5:4];
                    r_imm       <= r_instr[3:0];
                    r_pc_out    <= r_instr_pc;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= w_pc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef INSTR_CNT_EN
    logic [15:0] r_instr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (r_out_valid && out_ready && (r_instr_count != 16'hFFFF)) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

    // rom_en is gated by rst_n so it reads 0 while reset is held even though
    // the state register already sits in FETCH.
    assign rom_en    = (r_state == S_FETCH) && rst_n;
    assign rom_addr  = r_pc;
    assign out_valid = r_out_valid;
    assign opcode    = r_opcode;
    assign dst       = r_dst;
    assign src       = r_src;
    assign imm       = r_imm;
    assign pc_out    = r_pc_out;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        rom_en;
    logic [1:0]  rom_addr;
    logic [11:0] rom_instr;
    logic        jump_en;
    logic [1:0]  jump_addr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [1:0]  dst;
    logic [1:0]  src;
    logic [3:0]  imm;
    logic [1:0]  pc_out;
    logic        halted;
`ifdef INSTR_CNT_EN
    logic [15:0] instr_count;
`endif

    logic [11:0] rom [4];
    assign rom_instr = rom[rom_addr];

    instr_fetch_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_instr (rom_instr),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .dst       (dst),
        .src       (src),
        .imm       (imm),
        .pc_out    (pc_out),
        .halted    (halted)
`ifdef INSTR_CNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] word;
        logic [3:0]  op;
        logic [1:0]  dst;
        logic [1:0]  src;
        logic [3:0]  imm;
        logic [1:0]  pc;
        int          lat;
    } vec_t;

    vec_t prog [4];
    vec_t wrap [6];
    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns the number of falling edges until out_valid is seen, -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_valid timeout actual=0 required=1");
        cyc = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst opcode",    32'(opcode),    0);
        check("rst dst",       32'(dst),       0);
        check("rst src",       32'(src),       0);
        check("rst imm",       32'(imm),       0);
        check("rst pc_out",    32'(pc_out),    0);
        check("rst halted",    32'(halted),    0);
        check("rst rom_en",    32'(rom_en),    0);
`ifdef INSTR_CNT_EN
        check("rst instr_count", 32'(instr_count), 0);
`endif
        rst_n = 1'b1;
        #1;
        check("post-rst rom_en", 32'(rom_en), 1);
    endtask

    task automatic check_vec(input string tag, input vec_t v, input int cyc);
        check({tag, " latency"}, 32'(cyc),    32'(v.lat));
        check({tag, " opcode"},  32'(opcode), 32'(v.op));
        check({tag, " dst"},     32'(dst),    32'(v.dst));
        check({tag, " src"},     32'(src),    32'(v.src));
        check({tag, " imm"},     32'(imm),    32'(v.imm));
        check({tag, " pc_out"},  32'(pc_out), 32'(v.pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        run = 1'b0;
        jump_en = 1'b0;
        jump_addr = 2'd0;
        out_ready = 1'b1;

        prog[0] = '{12'h1A5, 4'h1, 2'd2, 2'd2, 4'h5, 2'd0, 2};
        prog[1] = '{12'h2B6, 4'h2, 2'd2, 2'd3, 4'h6, 2'd1, 3};
        prog[2] = '{12'h3C7, 4'h3, 2'd3, 2'd0, 4'h7, 2'd2, 3};
        prog[3] = '{12'hF00, 4'hF, 2'd0, 2'd0, 4'h0, 2'd3, 3};

        wrap[0] = '{12'h100, 4'h1, 2'd0, 2'd0, 4'h0, 2'd0, 2};
        wrap[1] = '{12'h101, 4'h1, 2'd0, 2'd0, 4'h1, 2'd1, 3};
        wrap[2] = '{12'h102, 4'h1, 2'd0, 2'd0, 4'h2, 2'd2, 3};
        wrap[3] = '{12'h103, 4'h1, 2'd0, 2'd0, 4'h3, 2'd3, 3};
        wrap[4] = '{12'h100, 4'h1, 2'd0, 2'd0, 4'h0, 2'd0, 3};
        wrap[5] = '{12'h101, 4'h1, 2'd0, 2'd0, 4'h1, 2'd1, 3};

        // Straight-line program ending in HALT
        for (int i = 0; i < 4; i++) rom[i] = prog[i].word;
        run = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_valid(cyc);
            check_vec($sformatf("prog[%0d]", i), prog[i], cyc);
        end
        repeat (3) begin
            @(negedge clk);
            check("halt halted",    32'(halted),    1);
            check("halt out_valid", 32'(out_valid), 0);
            check("halt rom_en",    32'(rom_en),    0);
            check("halt rom_addr",  32'(rom_addr),  3);
        end
`ifdef INSTR_CNT_EN
        check("instr_count after halt", 32'(instr_count), 4);
        repeat (4) @(negedge clk);
        check("instr_count stays", 32'(instr_count), 4);
`endif

        // Back-pressure on the first instruction
        out_ready = 1'b0;
        do_reset();
        wait_valid(cyc);
        check("stall latency", 32'(cyc), 2);
        repeat (5) begin
            @(negedge clk);
            check("stall out_valid", 32'(out_valid), 1);
            check("stall opcode",    32'(opcode),    1);
            check("stall dst",       32'(dst),       2);
            check("stall src",       32'(src),       2);
            check("stall imm",       32'(imm),       5);
            check("stall rom_en",    32'(rom_en),    0);
            check("stall rom_addr",  32'(rom_addr),  0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", 32'(out_valid), 0);
        check("release rom_addr",  32'(rom_addr),  1);
        check("release rom_en",    32'(rom_en),    1);

        // Jump to the HALT word; a jump coincident with HALT is ignored
        jump_en = 1'b1;
        jump_addr = 2'd3;
        do_reset();
        wait_valid(cyc);
        check_vec("jump first", prog[0], cyc);
        @(negedge clk);
        jump_addr = 2'd1;
        wait_valid(cyc);
        check("jump pc_out", 32'(pc_out), 3);
        check("jump opcode", 32'(opcode), 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("jump halted",   32'(halted),   1);
        check("jump rom_addr", 32'(rom_addr), 3);
        jump_en = 1'b0;
        jump_addr = 2'd0;

        // PC wrap-around with no HALT in the ROM
        for (int i = 0; i < 4; i++) rom[i] = wrap[i].word;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wait_valid(cyc);
            check_vec($sformatf("wrap[%0d]", i), wrap[i], cyc);
        end

        // run=0 parks in FETCH; a one-cycle run pulse still completes
        run = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle out_valid", 32'(out_valid), 0);
            check("idle rom_en",    32'(rom_en),    1);
            check("idle rom_addr",  32'(rom_addr),  2);
        end
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_valid(cyc);
        check("pulse pc_out", 32'(pc_out), 2);
        check("pulse imm",    32'(imm),    2);

        // Asynchronous reset while holding a valid instruction
        out_ready = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("pre-abort out_valid", 32'(out_valid), 1);
        check("pre-abort pc_out",    32'(pc_out),    2);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 0);
        check("abort pc_out",    32'(pc_out),    0);
        check("abort imm",       32'(imm),       0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_valid(cyc);
        check("after abort latency", 32'(cyc),    2);
        check("after abort pc_out",  32'(pc_out), 0);
        check("after abort imm",     32'(imm),    0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
